// File: rtl/seq_divider_unsigned_if.sv
// Start/busy/done handshake bundle for seq_divider_unsigned.
// master = requester driving operands, slave = divider returning results.
interface seq_divider_unsigned_if #(
  parameter int unsigned WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider_unsigned.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
// Optional macro DIVIDER_EARLY_EXIT_EN: finish in one cycle when dividend < divisor.
module seq_divider_unsigned #(
  parameter int unsigned WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  seq_divider_unsigned_if.slave bus
);
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dsr;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] q;
    logic [CW-1:0]    cnt;
    logic             skip;
    logic [WIDTH-1:0] quotient_r;
    logic [WIDTH-1:0] remainder_r;
    logic             dbz_r;

    logic             accept;
    logic             skip_in;
    logic             last;
    logic [WIDTH:0]   r_sh;
    logic             ge;
    logic [WIDTH-1:0] r_n;
    logic [WIDTH-1:0] q_n;

    assign accept = bus.start && (state != CALC);
    assign last   = (cnt == CW'(WIDTH - 1));

`ifdef DIVIDER_EARLY_EXIT_EN
    assign skip_in = (bus.divisor == '0) || (bus.dividend < bus.divisor);
`else
    assign skip_in = (bus.divisor == '0);
`endif

    // Restoring step; when no subtraction happens r_sh < divisor, so its top bit is 0.
    assign r_sh = {r, dvd[WIDTH-1]};
    assign ge   = (r_sh >= {1'b0, dsr});
    assign r_n  = ge ? WIDTH'(r_sh - {1'b0, dsr}) : r_sh[WIDTH-1:0];
    assign q_n  = {q[WIDTH-2:0], ge};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE, FIN: state_n = accept ? CALC : IDLE;
            CALC:      state_n = last ? FIN : CALC;
            default:   state_n = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state == CALC);
        bus.done = (state == FIN);
    end

    assign bus.quotient    = quotient_r;
    assign bus.remainder   = remainder_r;
    assign bus.div_by_zero = dbz_r;

    // Shortcut cases take one pass through CALC with the counter preset to its last
    // value, so they see one busy cycle like a normal request, then publish directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            dvd         <= '0;
            dsr         <= '0;
            r           <= '0;
            q           <= '0;
            cnt         <= '0;
            skip        <= 1'b0;
            quotient_r  <= '0;
            remainder_r <= '0;
            dbz_r       <= 1'b0;
        end else if (accept) begin
            dvd  <= bus.dividend;
            dsr  <= bus.divisor;
            r    <= '0;
            q    <= '0;
            cnt  <= skip_in ? CW'(WIDTH - 1) : '0;
            skip <= skip_in;
        end else if (state == CALC) begin
            if (skip) begin
                quotient_r  <= (dsr == '0) ? '1 : '0;
                remainder_r <= dvd;
                dbz_r       <= (dsr == '0);
            end else begin
                r   <= r_n;
                q   <= q_n;
                dvd <= {dvd[WIDTH-2:0], 1'b0};
                cnt <= cnt + 1'b1;
                if (last) begin
                    quotient_r  <= q_n;
                    remainder_r <= r_n;
                    dbz_r       <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_seq_divider_unsigned.sv
// Directed self-checking bench for seq_divider_unsigned at WIDTH=4.
// Honours DIVIDER_EARLY_EXIT_EN when computing expected latencies.
module tb_seq_divider_unsigned;
    logic clk;
    logic rst;
    int   passed;
    int   total;

    seq_divider_unsigned_if #(.WIDTH(4)) bus ();

    seq_divider_unsigned #(.WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Waits on negedges until done, bounded; lat counts negedges waited.
    task automatic wait_done(output int lat);
        lat = 0;
        while (bus.done !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    // Issues a request at the current negedge and returns at the negedge where done is high.
    task automatic do_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] eq, input logic [3:0] er, input logic edz,
                         input int elat);
        int lat;
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(negedge clk);
        bus.start    = 1'b0;
        bus.dividend = ~a;
        bus.divisor  = ~b;
        check({tag, "_busy"}, {31'd0, bus.busy}, 32'd1);
        wait_done(lat);
        check({tag, "_lat"}, lat, elat);
        check({tag, "_done"}, {31'd0, bus.done}, 32'd1);
        check({tag, "_busy_fin"}, {31'd0, bus.busy}, 32'd0);
        check({tag, "_q"}, {28'd0, bus.quotient}, {28'd0, eq});
        check({tag, "_r"}, {28'd0, bus.remainder}, {28'd0, er});
        check({tag, "_dz"}, {31'd0, bus.div_by_zero}, {31'd0, edz});
    endtask

    initial begin
        int lat;
        int elat;
        logic saw_done;
        passed = 0;
        total  = 0;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.dividend = '0;
        bus.divisor = '0;

        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_q", {28'd0, bus.quotient}, 32'd0);
        check("rst_r", {28'd0, bus.remainder}, 32'd0);
        check("rst_dz", {31'd0, bus.div_by_zero}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        do_op("basic", 4'd13, 4'd3, 4'd4, 4'd1, 1'b0, 4);
        @(negedge clk);
        check("basic_pulse", {31'd0, bus.done}, 32'd0);

        do_op("dbz", 4'd9, 4'd0, 4'd15, 4'd9, 1'b1, 1);
        do_op("after_dbz", 4'd15, 4'd1, 4'd15, 4'd0, 1'b0, 4);
        @(negedge clk);

`ifdef DIVIDER_EARLY_EXIT_EN
        elat = 1;
`else
        elat = 4;
`endif
        do_op("early", 4'd2, 4'd7, 4'd0, 4'd2, 1'b0, elat);
        @(negedge clk);

        // Busy protection: second start in CALC cycle 2 must be ignored.
        bus.start = 1'b1; bus.dividend = 4'd12; bus.divisor = 4'd5;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = 4'd1; bus.divisor = 4'd1;
        @(negedge clk);
        bus.start = 1'b0; bus.dividend = 4'd0; bus.divisor = 4'd0;
        wait_done(lat);
        check("bp_lat", lat, 2);
        check("bp_q", {28'd0, bus.quotient}, 32'd2);
        check("bp_r", {28'd0, bus.remainder}, 32'd2);
        @(negedge clk);
        check("bp_no_restart", {31'd0, bus.busy}, 32'd0);
        check("bp_pulse", {31'd0, bus.done}, 32'd0);

        // Reset in CALC cycle 2 aborts with no done.
        bus.start = 1'b1; bus.dividend = 4'd14; bus.divisor = 4'd3;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_busy", {31'd0, bus.busy}, 32'd0);
        check("mid_done", {31'd0, bus.done}, 32'd0);
        check("mid_q", {28'd0, bus.quotient}, 32'd0);
        check("mid_r", {28'd0, bus.remainder}, 32'd0);
        check("mid_dz", {31'd0, bus.div_by_zero}, 32'd0);
        rst = 1'b0;
        saw_done = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (bus.done === 1'b1) saw_done = 1'b1;
        end
        check("mid_no_done", {31'd0, saw_done}, 32'd0);
        do_op("after_mid", 4'd14, 4'd3, 4'd4, 4'd2, 1'b0, 4);

        // Back-to-back sweep: each request is issued in the previous FIN cycle.
        for (int b = 1; b < 16; b++) begin
            for (int a = 0; a < 16; a++) begin
                elat = 4;
`ifdef DIVIDER_EARLY_EXIT_EN
                if (a < b) elat = 1;
`endif
                do_op("sweep", 4'(a), 4'(b), 4'(a / b), 4'(a % b), 1'b0, elat);
            end
        end
        @(negedge clk);
        check("end_idle", {31'd0, bus.busy}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
